pm_spm_ctrl: RTL

PM_SPM_CTRL -- requirements
Module: pm_spm_ctrl

---
 rtl/pm_spm_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/pm_spm_ctrl.sv
// Self-programming controller: buffers one PM page from fill strobes, then erases or
// writes that page through the single-port PM, stalling CPU fetches meanwhile.
module pm_spm_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 13,
    parameter int PAGE_W    = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    output logic [WORD_SIZE-1:0]      cpu_data_o,
    output logic                      cpu_stall_o,
    input  logic                      spm_fill_i,
    input  logic [PAGE_W-1:0]         spm_off_i,
    input  logic [WORD_SIZE-1:0]      spm_data_i,
    input  logic                      spm_erase_i,
    input  logic                      spm_write_i,
    input  logic [ADDR_W-PAGE_W-1:0]  spm_page_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ADDR_W-1:0]         pm_addr_o,
    output logic                      pm_we_o,
    output logic [WORD_SIZE-1:0]      pm_data_o,
    input  logic [WORD_SIZE-1:0]      pm_data_i
);

    localparam int unsigned DEPTH = 1 << PAGE_W;

    typedef enum logic [1:0] {IDLE, ERASE, WRITE, DONE} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [PAGE_W-1:0]         r_cnt;
    logic [ADDR_W-PAGE_W-1:0]  r_page;
    logic [WORD_SIZE-1:0]      r_buf [DEPTH];
    logic                      w_start;
    logic                      w_last;

    assign w_start    = (r_state == IDLE) && (spm_erase_i || spm_write_i);
    assign w_last     = (r_cnt == '1);
    assign cpu_data_o = pm_data_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_page  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_page <= spm_page_i;
                r_cnt  <= '0;
            end else if (r_state == ERASE || r_state == WRITE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (spm_erase_i)      w_next = ERASE;
                else if (spm_write_i) w_next = WRITE;
            end
            ERASE, WRITE: if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        pm_addr_o   = cpu_addr_i;
        pm_we_o     = 1'b0;
        pm_data_o   = '1;
        cpu_stall_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            ERASE: begin
                pm_addr_o   = {r_page, r_cnt};
                pm_we_o     = 1'b1;
                cpu_stall_o = 1'b1;
                busy_o      = 1'b1;
            end
            WRITE: begin
                pm_addr_o   = {r_page, r_cnt};
                pm_we_o     = 1'b1;
                pm_data_o   = r_buf[r_cnt];
                cpu_stall_o = 1'b1;
                busy_o      = 1'b1;
            end
            DONE: begin
                cpu_stall_o = 1'b1;
                done_o      = 1'b1;
            end
            default: ;
        endcase
    end

    // Each word is returned to all ones as it is written, so the next page starts blank.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_buf[i[PAGE_W-1:0]] <= '1;
        end else if (r_state == IDLE && spm_fill_i) begin
            r_buf[spm_off_i] <= spm_data_i;
        end else if (r_state == WRITE) begin
            r_buf[r_cnt] <= '1;
        end
    end

endmodule
